dp_mem_rf: RTL and testbench



---
 rtl/dp_mem_rf.sv | 88 ++++++++
 tb/tb_dp_mem_rf.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/dp_mem_rf.sv
// dp_mem_rf: true dual-port, read-first synchronous RAM with optional
// per-port output pipeline register. Port B wins same-address write collisions.
module dp_mem_rf #(
  parameter int unsigned DEPTH   = 10,
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned OUTREGA = 1,
  parameter int unsigned OUTREGB = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             wea,
  input  logic [DEPTH-1:0] addra,
  input  logic [WIDTH-1:0] dia,
  output logic [WIDTH-1:0] doa,
  input  logic             enb,
  input  logic             web,
  input  logic [DEPTH-1:0] addrb,
  input  logic [WIDTH-1:0] dib,
  output logic [WIDTH-1:0] dob
);

  localparam int unsigned WORDS = 2 ** DEPTH;

  // Storage starts at zero; reset deliberately never touches it.
  logic [WIDTH-1:0] mem [WORDS] = '{default: '0};
  logic [WIDTH-1:0] rda;
  logic [WIDTH-1:0] rdb;

  // Array writes; B is assigned last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (ena && wea) mem[addra] <= dia;
      if (enb && web) mem[addrb] <= dib;
    end
  end

  // Port A read latch: samples pre-write contents (read-first), holds when disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rda <= '0;
    end else if (ena) begin
      rda <= mem[addra];
    end
  end

  // Port B read latch: same read-first behaviour as port A.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdb <= '0;
    end else if (enb) begin
      rdb <= mem[addrb];
    end
  end

  generate
    if (OUTREGA != 0) begin : g_outrega
      logic [WIDTH-1:0] ora;
      // Port A output pipeline stage, free-running (not gated by ena).
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ora <= '0;
        end else begin
          ora <= rda;
        end
      end
      assign doa = ora;
    end else begin : g_noouta
      assign doa = rda;
    end

    if (OUTREGB != 0) begin : g_outregb
      logic [WIDTH-1:0] orb;
      // Port B output pipeline stage, free-running (not gated by enb).
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          orb <= '0;
        end else begin
          orb <= rdb;
        end
      end
      assign dob = orb;
    end else begin : g_nooutb
      assign dob = rdb;
    end
  endgenerate

endmodule

// File: tb/tb_dp_mem_rf.sv
// tb_dp_mem_rf: directed checks of dp_mem_rf in the default build (A latency 2,
// B latency 1) and in a swapped-latency build (A latency 1, B latency 2).
module tb_dp_mem_rf;

  logic        clk = 1'b0;
  logic        rst;

  logic        ena, wea, enb, web;
  logic [9:0]  addra, addrb;
  logic [31:0] dia, dib;
  logic [31:0] doa, dob;

  logic        ena2, wea2, enb2, web2;
  logic [9:0]  addra2, addrb2;
  logic [31:0] dia2, dib2;
  logic [31:0] doa2, dob2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dp_mem_rf #(.DEPTH(10), .WIDTH(32), .OUTREGA(1), .OUTREGB(0)) dut (
    .clk(clk), .rst(rst),
    .ena(ena), .wea(wea), .addra(addra), .dia(dia), .doa(doa),
    .enb(enb), .web(web), .addrb(addrb), .dib(dib), .dob(dob)
  );

  dp_mem_rf #(.DEPTH(10), .WIDTH(32), .OUTREGA(0), .OUTREGB(1)) dut2 (
    .clk(clk), .rst(rst),
    .ena(ena2), .wea(wea2), .addra(addra2), .dia(dia2), .doa(doa2),
    .enb(enb2), .web(web2), .addrb(addrb2), .dib(dib2), .dob(dob2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    ena = 1'b0; wea = 1'b0; addra = 10'd0; dia = 32'd0;
    enb = 1'b0; web = 1'b0; addrb = 10'd0; dib = 32'd0;
    ena2 = 1'b0; wea2 = 1'b0; addra2 = 10'd0; dia2 = 32'd0;
    enb2 = 1'b0; web2 = 1'b0; addrb2 = 10'd0; dib2 = 32'd0;
    #2;
    check("reset_doa", doa, 32'h0);
    check("reset_dob", dob, 32'h0);
    tick(); tick();
    rst = 1'b0;
    tick();
    check("idle_doa", doa, 32'h0);
    check("idle_dob", dob, 32'h0);

    // Port A writes addr 1 and addr 2.
    ena = 1'b1; wea = 1'b1; addra = 10'd1; dia = 32'h11223344;
    tick();
    addra = 10'd2; dia = 32'h55667788;
    tick();
    // Read addr 1 then addr 2 on A (latency 2).
    wea = 1'b0; addra = 10'd1;
    tick();
    addra = 10'd2;
    tick();
    check("a_read_addr1", doa, 32'h11223344);

    // A reads addr 2 while B writes it on the same edge.
    enb = 1'b1; web = 1'b1; addrb = 10'd2; dib = 32'hCAFEDECA;
    tick();
    check("a_read_addr2", doa, 32'h55667788);
    check("b_readfirst", dob, 32'h55667788);
    web = 1'b0;
    tick();
    check("a_readfirst", doa, 32'h55667788);
    check("b_after_write", dob, 32'hCAFEDECA);
    tick();
    check("a_after_write", doa, 32'hCAFEDECA);

    // Both ports write addr 5; B must win.
    wea = 1'b1; addra = 10'd5; dia = 32'hAAAA0000;
    web = 1'b1; addrb = 10'd5; dib = 32'hBBBB0000;
    tick();
    wea = 1'b0; web = 1'b0;
    tick();
    check("b_collision", dob, 32'hBBBB0000);
    tick();
    check("a_collision", doa, 32'hBBBB0000);

    // B disabled: write to addr 3 ignored, dob holds.
    ena = 1'b0;
    enb = 1'b0; web = 1'b1; addrb = 10'd3; dib = 32'hDEADBEEF;
    tick();
    check("b_hold1", dob, 32'hBBBB0000);
    tick();
    check("b_hold2", dob, 32'hBBBB0000);
    enb = 1'b1; web = 1'b0;
    tick();
    check("b_addr3_unwritten", dob, 32'h0);

    // Reset with reads outstanding; writes attempted during reset are dropped.
    ena = 1'b1; wea = 1'b0; addra = 10'd1;
    addrb = 10'd2;
    tick();
    check("b_pre_reset", dob, 32'hCAFEDECA);
    rst = 1'b1;
    wea = 1'b1; dia = 32'hFFFFFFFF;
    web = 1'b1; dib = 32'hFFFFFFFF;
    #1;
    check("rst_async_doa", doa, 32'h0);
    check("rst_async_dob", dob, 32'h0);
    tick();
    check("rst_held_doa", doa, 32'h0);
    rst = 1'b0;
    wea = 1'b0; web = 1'b0;
    #1;
    check("rst_release_doa", doa, 32'h0);
    check("rst_release_dob", dob, 32'h0);
    tick();
    check("post_rst_doa_stage", doa, 32'h0);
    check("post_rst_dob", dob, 32'hCAFEDECA);
    tick();
    check("post_rst_doa", doa, 32'h11223344);

    // Swapped-latency build: A latency 1, B latency 2.
    ena2 = 1'b1; wea2 = 1'b1; addra2 = 10'd1; dia2 = 32'h11223344;
    tick();
    wea2 = 1'b0;
    enb2 = 1'b1; addrb2 = 10'd1;
    tick();
    check("lat_a1", doa2, 32'h11223344);
    check("lat_b_stage", dob2, 32'h0);
    addra2 = 10'd0; addrb2 = 10'd0;
    tick();
    check("lat_a_next", doa2, 32'h0);
    check("lat_b2", dob2, 32'h11223344);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
